multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// - Multi-cycle sequencer for the MIPS-subset datapath (add/sub/and/or/nor/xor/addi/lw/sw).
// - Replaces single-cycle decode with a state machine that steps one instruction over
//   FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes per state.
// - Handshakes with a shared variable-latency instruction/data memory via mem_ready.
// - Counts retired instructions and flags illegal opcodes and memory timeouts.
// PARAMETERS
// - WAIT_LIMIT  16  max consecutive no-ready cycles in a memory wait state before bus_error
// - CNT_W       16  width of retired-instruction counter
// PORTS
// - clk          in   1      clock, rising edge
// - reset        in   1      synchronous, active-high
// - run          in   1      1 = allow new fetch; sampled only in FETCH
// - instruction  in   32     IR contents (valid from the cycle after ir_write)
// - mem_ready    in   1      memory completes current read/write this cycle
// - pc_write     out  1      PC <= ALU result (PC+4)
// - ir_write     out  1      IR <= mem read data
// - i_or_d       out  1      memory address: 0 = PC, 1 = ALU out
// - mem_read     out  1      memory read request
// - mem_write    out  1      memory write request
// - reg_write    out  1      register file write enable
// - mem_to_reg   out  1      WB data: 0 = ALU out, 1 = mem data
// - reg_dst      out  1      dest reg: 0 = rt, 1 = rd
// - alu_src_a    out  1      0 = PC, 1 = rs
// - alu_src_b    out  2      00 = rt, 01 = const 4, 10 = sign-ext imm
// - alu_func     out  6      ALU op (MIPS funct code)
// - state        out  4      current state (encoding below)
// - instr_done   out  1      1-cycle pulse on retire
// - illegal      out  1      1-cycle pulse on unsupported opcode/funct
// - bus_error    out  1      sticky; set on memory timeout, cleared by reset only
// - retired      out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
// - States: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 ADDR=4 MEM_RD=5 MEM_WR=6 WB_R=7 WB_I=8
//   WB_MEM=9 HALT=10. Reset -> FETCH; retired=0, bus_error=0, wait_cnt=0.
// - Strobes are Moore outputs decoded from state (pc_write/ir_write also gated by mem_ready).
//   All strobes are 0 in any cycle with reset=1 and in HALT. Unlisted strobes are 0.
// - FETCH: run=0 -> idle, all 0, wait_cnt held 0. run=1 -> mem_read=1, i_or_d=0,
//   alu_src_a=0, alu_src_b=01, alu_func=100000. mem_ready=1 -> ir_write=1, pc_write=1, -> DECODE.
// - DECODE (1 cycle): op 000000 + funct in {100000,100010,100100,100101,100110,100111} -> EXEC_R;
//   op 001000 -> EXEC_I; op 100011/101011 -> ADDR; otherwise illegal=1, -> FETCH, no retire.
// - EXEC_R: alu_src_a=1, alu_src_b=00, alu_func=funct -> WB_R.
// - EXEC_I/ADDR: alu_src_a=1, alu_src_b=10, alu_func=100000 -> WB_I / (lw MEM_RD, sw MEM_WR).
// - MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready -> WB_MEM.
// - MEM_WR: mem_write=1, i_or_d=1; mem_ready -> FETCH, retire.
// - WB_R: reg_write=1, reg_dst=1. WB_I: reg_write=1, reg_dst=0. WB_MEM: reg_write=1,
//   mem_to_reg=1, reg_dst=0. All -> FETCH, retire.
// - Retire: instr_done=1 that cycle; retired increments next edge; 2^CNT_W-1 wraps to 0.
// - Latency with mem_ready=1: R/addi 4 cycles, lw 5, sw 4; each wait cycle adds 1.
// - Wait: wait_cnt increments per request cycle with mem_ready=0, clears on state exit.
//   mem_ready=0 with wait_cnt==WAIT_LIMIT-1 -> HALT, bus_error=1. mem_ready=1 wins that cycle.
// - HALT: absorbing until reset; retired frozen.
// - Reset mid-instruction: next cycle FETCH, all strobes 0, no partial write or retire.
// TESTING
// - ADD 0x014A4020, mem_ready=1 -> states 0,1,2,7; alu_func=100000 in EXEC_R; reg_write=reg_dst=1
//   in WB_R; instr_done pulse; retired=1.
// - LW 0x8D280008, mem_ready low 3 cycles in MEM_RD -> mem_read=i_or_d=1 for 4 cycles; WB_MEM
//   mem_to_reg=1; 8 cycles total.
// - SW 0xAD28000C -> MEM_WR mem_write=1, i_or_d=1; reg_write never 1; retired increments.
// - J 0x08000000 -> illegal pulse in DECODE, back to FETCH; no reg_write/mem_write; retired unchanged.
// - FETCH with mem_ready=0 for 16 cycles -> HALT, bus_error=1, strobes 0 until reset; ready on 16th completes.
// - reset during MEM_WR -> next cycle state=0, mem_write=0, retired=0, bus_error=0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle sequencer for a MIPS-subset datapath (add/sub/and/or/nor/xor,
// addi, lw, sw). One instruction is stepped through FETCH/DECODE/EXEC/MEM/WB
// states and the datapath strobes are decoded from the current state. A shared
// variable-latency memory is handshaked through mem_ready; a request that sees
// no ready for WAIT_LIMIT consecutive cycles parks the sequencer in HALT with
// a sticky bus_error.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               allows a new fetch (looked at only in FETCH)
//   instruction       IR contents, valid from the cycle after ir_write
//   mem_ready         memory completes the current read/write this cycle
//   pc_write..alu_func  datapath strobes (Moore, pc_write/ir_write gated by mem_ready)
//   state             current state encoding
//   instr_done        one-cycle pulse when an instruction retires
//   illegal           one-cycle pulse on an unsupported opcode/funct
//   bus_error         sticky memory-timeout flag, cleared only by reset
//   retired           retired-instruction counter, wraps to 0

module multicycle_control #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instruction,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_func,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [1:0] SRC_B_RT   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  // The wait counter only ever reaches WAIT_LIMIT-1, one extra bit keeps
  // small limits (e.g. 1) well-formed.
  localparam int WC_W = $clog2(WAIT_LIMIT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_LIMIT - 1);

  state_t          cur_state;
  state_t          nxt_state;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_cnt_nxt;
  logic            timeout_hit;
  logic            funct_ok;

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign state  = cur_state;

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:6];

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR: funct_ok = 1'b1;
      default:                                       funct_ok = 1'b0;
    endcase
  end

  // Next-state and strobe decode. Everything is forced low while reset is
  // asserted so a reset mid-instruction never leaks a partial write.
  always_comb begin
    nxt_state    = cur_state;
    wait_cnt_nxt = '0;
    timeout_hit  = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_RT;
    alu_func     = 6'b000000;
    instr_done   = 1'b0;
    illegal      = 1'b0;

    if (!reset) begin
      case (cur_state)
        S_FETCH: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            alu_func  = FN_ADD;
            // A ready on the last permitted cycle still completes the fetch.
            if (mem_ready) begin
              ir_write  = 1'b1;
              pc_write  = 1'b1;
              nxt_state = S_DECODE;
            end else if (wait_cnt == WAIT_LAST) begin
              timeout_hit = 1'b1;
              nxt_state   = S_HALT;
            end else begin
              wait_cnt_nxt = wait_cnt + 1'b1;
            end
          end
        end

        S_DECODE: begin
          if (opcode == OP_RTYPE && funct_ok) begin
            nxt_state = S_EXEC_R;
          end else if (opcode == OP_ADDI) begin
            nxt_state = S_EXEC_I;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            nxt_state = S_ADDR;
          end else begin
            illegal   = 1'b1;
            nxt_state = S_FETCH;
          end
        end

        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_RT;
          alu_func  = funct;
          nxt_state = S_WB_R;
        end

        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_func  = FN_ADD;
          nxt_state = S_WB_I;
        end

        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_func  = FN_ADD;
          nxt_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end

        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            nxt_state = S_WB_MEM;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_hit = 1'b1;
            nxt_state   = S_HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end

        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            nxt_state  = S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_hit = 1'b1;
            nxt_state   = S_HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end

        S_WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end

        S_WB_I: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end

        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          nxt_state  = S_FETCH;
        end

        S_HALT: begin
          nxt_state = S_HALT;
        end

        default: begin
          nxt_state = S_FETCH;
        end
      endcase
    end
  end

  // State, wait counter, sticky bus error and retire counter. The retire
  // counter is free-running modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
      retired   <= '0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= wait_cnt_nxt;
      if (timeout_hit) begin
        bus_error <= 1'b1;
      end
      if (instr_done) begin
        retired <= retired + 1'b1;
      end
    end
  end

endmodule
